// File: rtl/tmds_align_ctl.sv
// tmds_align_ctl: per-channel TMDS word-alignment controller (bitslip search, lock, lock supervision)
//   pclk       in   pixel clock, all logic on rising edge
//   reset_n    in   asynchronous active-low reset
//   enable     in   run/hold; low returns to IDLE on the next edge
//   rawdata    in   [9:0] raw deserialized symbol
//   bitslip    out  one-cycle slip request to the deserializer
//   aligned    out  word alignment achieved (decoder iamvld)
//   slip_cnt   out  [3:0] current slip position 0..9
//   state      out  [1:0] 0=IDLE 1=SEARCH 2=SLIP 3=LOCKED
//   lock_lost  out  one-cycle pulse on LOCKED->SEARCH
// Optional (TMDS_ALIGN_STATS_EN): stats_clr in, loss_cnt[15:0] out, slip_total[15:0] out
module tmds_align_ctl #(
  parameter int WIN_LEN      = 1024,
  parameter int TOKEN_THRESH = 64,
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_TIMEOUT = 8192
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [9:0] rawdata,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_cnt,
  output logic [1:0] state,
  output logic       lock_lost
`ifdef TMDS_ALIGN_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] loss_cnt,
  output logic [15:0] slip_total
`endif
);
  localparam int WW = $clog2(WIN_LEN);
  localparam int TW = $clog2(TOKEN_THRESH + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int GW = $clog2(LOCK_TIMEOUT);
  localparam logic [WW-1:0] WIN_LAST    = WW'(WIN_LEN - 1);
  localparam logic [TW:0]   THRESH      = (TW+1)'(TOKEN_THRESH);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, SLIP, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [TW-1:0] tok_cnt_q, tok_cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    slip_q, slip_d;
  logic          tok_q, tok_d;
  logic          aligned_q, aligned_d;
  logic          bitslip_q, bitslip_d;
  logic          lock_lost_q, lock_lost_d;
  logic [TW:0]   tok_sum;

  assign tok_d = (rawdata == 10'b1101010100) || (rawdata == 10'b0010101011) ||
                 (rawdata == 10'b0101010100) || (rawdata == 10'b1010101011);
  // tok_cnt never exceeds THRESH because reaching it leaves SEARCH, so the sum saturates naturally
  assign tok_sum = {1'b0, tok_cnt_q} + (TW+1)'(tok_q);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    tok_cnt_d   = tok_cnt_q;
    settle_d    = settle_q;
    gap_d       = gap_q;
    slip_d      = slip_q;
    aligned_d   = aligned_q;
    bitslip_d   = 1'b0;
    lock_lost_d = 1'b0;
    if (!enable) begin
      state_d   = IDLE;
      aligned_d = 1'b0;
      win_d     = '0;
      tok_cnt_d = '0;
      settle_d  = '0;
      gap_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = SEARCH;
          aligned_d = 1'b0;
          win_d     = '0;
          tok_cnt_d = '0;
        end
        SEARCH: begin
          win_d     = win_q + 1'b1;
          tok_cnt_d = tok_sum[TW-1:0];
          if (tok_sum == THRESH) begin
            state_d   = LOCKED;
            aligned_d = 1'b1;
            gap_d     = '0;
          end else if (win_q == WIN_LAST) begin
            state_d   = SLIP;
            bitslip_d = 1'b1;
            slip_d    = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
            settle_d  = '0;
          end
        end
        SLIP: begin
          settle_d = settle_q + 1'b1;
          if (settle_q == SETTLE_LAST) begin
            state_d   = SEARCH;
            win_d     = '0;
            tok_cnt_d = '0;
          end
        end
        LOCKED: begin
          gap_d = tok_q ? '0 : gap_q + 1'b1;
          if (!tok_q && gap_q == GAP_LAST) begin
            state_d     = SEARCH;
            aligned_d   = 1'b0;
            lock_lost_d = 1'b1;
            win_d       = '0;
            tok_cnt_d   = '0;
            gap_d       = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      win_q       <= '0;
      tok_cnt_q   <= '0;
      settle_q    <= '0;
      gap_q       <= '0;
      slip_q      <= '0;
      tok_q       <= 1'b0;
      aligned_q   <= 1'b0;
      bitslip_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      tok_cnt_q   <= tok_cnt_d;
      settle_q    <= settle_d;
      gap_q       <= gap_d;
      slip_q      <= slip_d;
      tok_q       <= tok_d;
      aligned_q   <= aligned_d;
      bitslip_q   <= bitslip_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bitslip   = bitslip_q;
  assign aligned   = aligned_q;
  assign slip_cnt  = slip_q;
  assign state     = state_q;
  assign lock_lost = lock_lost_q;

`ifdef TMDS_ALIGN_STATS_EN
  logic [15:0] loss_q, slip_tot_q;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      loss_q     <= '0;
      slip_tot_q <= '0;
    end else begin
      loss_q     <= stats_clr ? '0 : (lock_lost_q && loss_q != 16'hFFFF) ? loss_q + 16'd1 : loss_q;
      slip_tot_q <= stats_clr ? '0 : (bitslip_q && slip_tot_q != 16'hFFFF) ? slip_tot_q + 16'd1 : slip_tot_q;
    end
  end

  assign loss_cnt   = loss_q;
  assign slip_total = slip_tot_q;
`endif
endmodule

// File: tb/tb_tmds_align_ctl.sv
// tb_tmds_align_ctl: randomized self-checking bench for tmds_align_ctl against a behavioural model
module tb_tmds_align_ctl;
  localparam int WL = 32, TH = 4, SC = 4, LT = 16;

  logic       pclk = 1'b0, reset_n = 1'b0, enable = 1'b0, stats_clr = 1'b0;
  logic [9:0] rawdata = '0;
  logic       bitslip, aligned, lock_lost;
  logic [3:0] slip_cnt;
  logic [1:0] state;
`ifdef TMDS_ALIGN_STATS_EN
  logic [15:0] loss_cnt, slip_total;
`endif

  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  // model: mode 0=idle 1=search 2=slip 3=locked
  int m_mode, m_age, m_hits, m_wait, m_quiet, m_pos, m_loss, m_slips;
  bit m_al, m_bs, m_ll, m_tq;

  tmds_align_ctl #(.WIN_LEN(WL), .TOKEN_THRESH(TH), .SETTLE_CYC(SC), .LOCK_TIMEOUT(LT)) dut (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .rawdata(rawdata),
    .bitslip(bitslip), .aligned(aligned), .slip_cnt(slip_cnt), .state(state),
    .lock_lost(lock_lost)
`ifdef TMDS_ALIGN_STATS_EN
    , .stats_clr(stats_clr), .loss_cnt(loss_cnt), .slip_total(slip_total)
`endif
  );

  always #5 pclk = ~pclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit is_tok(input logic [9:0] d);
    foreach (toks[i]) if (d == toks[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] gen(input int p);
    logic [9:0] d;
    if (int'($urandom_range(99)) < p) return toks[$urandom_range(3)];
    do d = 10'($urandom_range(1023)); while (is_tok(d));
    return d;
  endfunction

  task automatic model_reset();
    {m_mode, m_age, m_hits, m_wait, m_quiet, m_pos, m_loss, m_slips} = '0;
    {m_al, m_bs, m_ll, m_tq} = '0;
  endtask

  task automatic model_edge(input bit en, input logic [9:0] raw, input bit clr);
    bit seen;
    seen = m_tq;
    m_tq = is_tok(raw);
    if (clr) begin
      m_loss = 0;
      m_slips = 0;
    end else begin
      if (m_ll) m_loss = (m_loss < 65535) ? m_loss + 1 : m_loss;
      if (m_bs) m_slips = (m_slips < 65535) ? m_slips + 1 : m_slips;
    end
    m_bs = 0;
    m_ll = 0;
    if (!en) begin
      m_mode = 0; m_al = 0; m_age = 0; m_hits = 0; m_wait = 0; m_quiet = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_age = 0; m_hits = 0;
    end else if (m_mode == 1) begin
      m_hits = (m_hits + int'(seen) > TH) ? TH : m_hits + int'(seen);
      if (m_hits == TH) begin
        m_mode = 3; m_al = 1; m_quiet = 0;
      end else if (m_age == WL - 1) begin
        m_mode = 2; m_bs = 1; m_pos = (m_pos + 1) % 10; m_wait = 0;
      end else m_age++;
    end else if (m_mode == 2) begin
      m_wait++;
      if (m_wait == SC) begin
        m_mode = 1; m_age = 0; m_hits = 0;
      end
    end else begin
      if (seen) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == LT) begin
          m_mode = 1; m_al = 0; m_ll = 1; m_age = 0; m_hits = 0; m_quiet = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_mode));
    chk("aligned", 32'(aligned), 32'(m_al));
    chk("bitslip", 32'(bitslip), 32'(m_bs));
    chk("slip_cnt", 32'(slip_cnt), 32'(m_pos));
    chk("lock_lost", 32'(lock_lost), 32'(m_ll));
    chk("bs_ll_excl", 32'(bitslip & lock_lost), 32'd0);
`ifdef TMDS_ALIGN_STATS_EN
    chk("loss_cnt", 32'(loss_cnt), 32'(m_loss));
    chk("slip_total", 32'(slip_total), 32'(m_slips));
`endif
  endtask

  task automatic cycle(input bit en, input logic [9:0] raw, input bit clr = 1'b0);
    enable = en;
    rawdata = raw;
    stats_clr = clr;
    @(posedge pclk);
    cyc++;
    if (!reset_n) model_reset();
    else model_edge(en, raw, clr);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_aligned", 32'(aligned), 32'd0);
    chk("rst_slip_cnt", 32'(slip_cnt), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_bitslip", 32'(bitslip), 32'd0);
    model_reset();
  endtask

  initial begin
    int lat, last, npulse, nll, nbs, snap, ps [4];
    bit found;
    ps = '{0, 3, 25, 100};
    model_reset();
    // reset with toggling data, then immediate lock on constant token
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b1, (i % 2) ? toks[0] : 10'h3FF);
    reset_n = 1'b1;
    lat = 0;
    nbs = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, toks[0]);
      if (aligned && lat == 0) lat = i + 1;
      nbs += int'(bitslip);
    end
    chk("t1_lock_lat_ok", 32'(lat > 0 && lat <= 6), 32'd1);
    chk("t1_no_bitslip", 32'(nbs), 32'd0);
    // steady failure: slip period and wrap
    async_reset();
    reset_n = 1'b1;
    last = -1;
    npulse = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, gen(0));
      if (bitslip) begin
        if (last >= 0) chk("t2_period", 32'(cyc - last), 32'd36);
        last = cyc;
        npulse++;
      end
    end
    chk("t2_pulses", 32'(npulse), 32'd11);
    // lock loss after token-free run
    async_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, toks[$urandom_range(3)]);
    chk("t3_locked", 32'(state), 32'd3);
    nll = 0;
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, gen(0));
      nll += int'(lock_lost);
    end
    chk("t3_loss_pulses", 32'(nll), 32'd1);
    chk("t3_state", 32'(state), 32'd1);
    chk("t3_aligned", 32'(aligned), 32'd0);
    // token at gap 15 keeps lock
    for (int i = 0; i < 8; i++) cycle(1'b1, toks[$urandom_range(3)]);
    nll = 0;
    for (int i = 0; i < 31; i++) begin
      cycle(1'b1, (i == 15) ? toks[$urandom_range(3)] : gen(0));
      nll += int'(lock_lost);
    end
    chk("t3_kept_no_loss", 32'(nll), 32'd0);
    chk("t3_kept_state", 32'(state), 32'd3);
    // fourth token lands on the last window cycle
    async_reset();
    reset_n = 1'b1;
    snap = int'(slip_cnt);
    nbs = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(1'b1, (m_mode == 1 && m_age >= 27 && m_age <= 30) ? toks[$urandom_range(3)] : gen(0));
      nbs += int'(bitslip);
      found = (m_mode == 3);
    end
    chk("t4_state", 32'(state), 32'd3);
    chk("t4_no_bitslip", 32'(nbs), 32'd0);
    chk("t4_slip_cnt", 32'(slip_cnt), 32'(snap));
    // disable during SLIP
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle(1'b1, gen(0));
      found = (m_mode == 2);
    end
    chk("t5_reach_slip", 32'(found), 32'd1);
    snap = int'(slip_cnt);
    cycle(1'b0, gen(0));
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_bitslip", 32'(bitslip), 32'd0);
    chk("t5_slip_held", 32'(slip_cnt), 32'(snap));
    for (int i = 0; i < 8; i++) cycle(1'b1, toks[$urandom_range(3)]);
    chk("t5_relocked", 32'(aligned), 32'd1);
    async_reset();
    reset_n = 1'b1;
`ifdef TMDS_ALIGN_STATS_EN
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) cycle(1'b1, toks[$urandom_range(3)]);
      for (int i = 0; i < 18; i++) cycle(1'b1, gen(0));
    end
    chk("t6_loss3", 32'(loss_cnt), 32'd3);
    for (int i = 0; i < 8; i++) cycle(1'b1, toks[$urandom_range(3)]);
    for (int i = 0; i < 18; i++) cycle(1'b1, gen(0), m_ll);
    chk("t6_loss_clr", 32'(loss_cnt), 32'd0);
`endif
    // randomized traffic blocks
    for (int b = 0; b < 40; b++) begin
      int p;
      p = ps[$urandom_range(3)];
      for (int i = 0; i < 40; i++)
        cycle($urandom_range(99) >= 2, gen(p), $urandom_range(99) < 5);
      if ($urandom_range(99) < 5) begin
        async_reset();
        reset_n = 1'b1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tmds_align_ctl.md
Name: tmds_align_ctl

Overview:
- Per-channel TMDS symbol word-alignment controller. It sits between the deserializer and the channel decoder.
- It watches the raw 10-bit symbol stream for the four DVI control tokens and issues single-cycle bitslip requests until tokens appear at the required density.
- Once that density is reached it asserts aligned, which drives the decoder's iamvld.
- While locked it supervises the stream and drops lock when token traffic stops.

Parameters:
- WIN_LEN, 1024: symbols per search window; counter width $clog2(WIN_LEN).
- TOKEN_THRESH, 64: control tokens in one window required to declare lock.
- SETTLE_CYC, 16: cycles waited after a bitslip before searching again.
- LOCK_TIMEOUT, 8192: consecutive token-free symbols tolerated while locked.

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run/hold; low forces IDLE synchronously.
- rawdata  in  10  raw deserialized symbol.
- bitslip  out  1  one-cycle slip request to the deserializer.
- aligned  out  1  word alignment achieved; feeds the decoder's iamvld.
- slip_cnt  out  4  current slip position, 0..9.
- state  out  2  0=IDLE, 1=SEARCH, 2=SLIP, 3=LOCKED.
- lock_lost  out  1  one-cycle pulse on LOCKED->SEARCH.

Behaviour:
- Reset: all outputs are 0, all counters are 0, and the FSM is in IDLE.
- Token detect:
  - tok_q is registered: rawdata at edge n equal to 1101010100, 0010101011, 0101010100 or 1010101011 gives tok_q=1 after edge n.
  - All counting uses tok_q, which adds 1 cycle of latency.
- IDLE:
  - aligned=0.
  - If enable=1: go to SEARCH and clear win_cnt and tok_cnt.
- SEARCH, each cycle:
  - win_cnt+1.
  - tok_cnt+tok_q, saturating at TOKEN_THRESH.
  - If tok_cnt+tok_q reaches TOKEN_THRESH: go to LOCKED, and aligned=1 from the next edge.
  - Else if win_cnt==WIN_LEN-1: go to SLIP.
  - If threshold and window end occur in the same cycle, lock wins and no slip is issued.
- SLIP:
  - On the entry edge, bitslip=1 for exactly one cycle.
  - slip_cnt increments, wrapping 9->0.
  - settle_cnt counts SETTLE_CYC cycles, then go to SEARCH with win_cnt and tok_cnt cleared.
  - tok_q is ignored during SLIP.
  - Slip period in steady failure: WIN_LEN+SETTLE_CYC cycles.
- LOCKED:
  - gap_cnt clears on tok_q=1 and increments otherwise.
  - When gap_cnt==LOCK_TIMEOUT-1 with tok_q=0: go to SEARCH, aligned=0 on the next edge, lock_lost=1 for that cycle, and counters clear.
  - No bitslip is issued in LOCKED.
- enable=0 in any state: next edge goes to IDLE.
  - aligned, bitslip and lock_lost go to 0.
  - win_cnt, tok_cnt, settle_cnt and gap_cnt clear.
  - slip_cnt is held, because the deserializer retains its slip position.
- reset_n low at any time: immediate return to reset values, including slip_cnt=0.
- bitslip and lock_lost are never asserted in the same cycle.

Optional Feature:
- Macro: TMDS_ALIGN_STATS_EN.
- When defined, the block adds:
  - Output loss_cnt[15:0]: increments on each lock_lost pulse and saturates at 16'hFFFF.
  - Input stats_clr: a synchronous clear of loss_cnt. It has priority over a simultaneous increment.
  - Output slip_total[15:0]: counts bitslip pulses with the same saturation and clear rules.
  - Both counters reset to 0 on reset_n and are unaffected by enable.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan (WIN_LEN=32, TOKEN_THRESH=4, SETTLE_CYC=4, LOCK_TIMEOUT=16):
1. Reset and immediate lock. Assert reset_n=0 with enable=1 and rawdata toggling; then release reset_n and drive constant rawdata=1101010100.
   - During reset: state=0, aligned=0, bitslip=0, slip_cnt=0.
   - After release: aligned=1 within 6 cycles, state=3, bitslip never asserted.
2. Non-token data with enable=1 for 400 cycles.
   - bitslip pulses exactly every 36 cycles.
   - slip_cnt steps 1..9 then 0 on the 10th pulse.
   - aligned stays 0.
3. Lock loss. Reach lock, then send 16 consecutive non-token symbols.
   - lock_lost=1 for one cycle, aligned=0, state=1.
   - A token inserted at gap 15 instead keeps lock.
4. Lock at window end. Place the 4th token on window cycle 31.
   - state=3, no bitslip, slip_cnt unchanged.
5. Disable and reset mid-operation.
   - enable=0 during SLIP: next edge state=0, bitslip=0, slip_cnt held.
   - reset_n=0 during LOCKED: aligned drops asynchronously, slip_cnt=0.
6. Statistics with TMDS_ALIGN_STATS_EN defined.
   - 3 lock losses give loss_cnt=3.
   - stats_clr in the same cycle as a 4th loss gives loss_cnt=0.
   - slip_total matches the number of bitslip pulses.
